// File: rtl/line_writer.sv
// Packs a character-pair stream into line records: one memory write per pair, one pointer-table write per line.
// Optional macro LINE_WRITER_ASCII_CHECK_EN replaces non-printable bytes with a space and adds the sticky err_ascii output.
module line_writer #(
    parameter int MEM_DEPTH = 256,
    parameter int MAX_LINES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_lhs,
    input  logic [7:0]  in_rhs,
    input  logic        in_last,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        ptr_we,
    output logic [7:0]  ptr_line,
    output logic [15:0] ptr_data,
    output logic [7:0]  line_count,
    output logic        full,
    output logic        err_overflow
`ifdef LINE_WRITER_ASCII_CHECK_EN
    ,
    output logic        err_ascii
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        COMMIT,
        DROP,
        FULL
    } state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);
    localparam logic [8:0] LINES_LIM = 9'(MAX_LINES);

    state_t      r_state;
    state_t      w_state_next;
    logic [8:0]  r_wr_addr;
    logic [7:0]  r_line_start;
    logic [7:0]  r_char_count;
    logic [8:0]  r_line_count;
    logic        r_in_ready;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_ptr_we;
    logic [7:0]  r_ptr_line;
    logic [15:0] r_ptr_data;
    logic        r_full;
    logic        r_err_overflow;

    logic        w_accept;
    logic        w_taking;
    logic        w_in_line;
    logic        w_overflow;
    logic [7:0]  w_count;
    logic [7:0]  w_len;
    logic [7:0]  w_start;
    logic [7:0]  w_lhs;
    logic [7:0]  w_rhs;
    logic        w_bad_byte;

    function automatic logic [7:0] f_clean(input logic [7:0] b);
`ifdef LINE_WRITER_ASCII_CHECK_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    function automatic logic f_is_bad(input logic [7:0] b);
        return (b < 8'h20 || b > 8'h7E);
    endfunction

    // A pair arriving in IDLE opens a fresh line, so its count starts at zero
    // and its start address is the current write address.
    always_comb begin
        w_accept   = in_valid & r_in_ready;
        w_taking   = w_accept && (r_state == IDLE || r_state == WRITE);
        w_in_line  = (r_state == WRITE);
        w_count    = w_in_line ? r_char_count : 8'd0;
        w_start    = w_in_line ? r_line_start : r_wr_addr[7:0];
        w_len      = w_count + 8'd1;
        w_overflow = (r_wr_addr == DEPTH_LIM) || (w_count == 8'd255);
        w_lhs      = f_clean(in_lhs);
        w_rhs      = f_clean(in_rhs);
        w_bad_byte = f_is_bad(in_lhs) | f_is_bad(in_rhs);
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, WRITE: begin
                if (w_accept) begin
                    if (w_overflow) w_state_next = in_last ? IDLE : DROP;
                    else            w_state_next = in_last ? COMMIT : WRITE;
                end
            end
            COMMIT:  w_state_next = (r_line_count + 9'd1 == LINES_LIM) ? FULL : IDLE;
            DROP:    if (w_accept && in_last) w_state_next = IDLE;
            FULL:    w_state_next = FULL;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr      <= 9'd0;
            r_line_start   <= 8'd0;
            r_char_count   <= 8'd0;
            r_line_count   <= 9'd0;
            r_in_ready     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 8'd0;
            r_mem_din      <= 16'h2020;
            r_ptr_we       <= 1'b0;
            r_ptr_line     <= 8'd0;
            r_ptr_data     <= 16'd0;
            r_full         <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_ptr_we   <= 1'b0;
            r_in_ready <= (w_state_next == IDLE) || (w_state_next == WRITE) ||
                          (w_state_next == DROP);
            if (w_taking) begin
                if (w_overflow) begin
                    r_err_overflow <= 1'b1;
                    if (w_in_line) r_wr_addr <= {1'b0, r_line_start};
                end else begin
                    r_mem_we     <= 1'b1;
                    r_mem_addr   <= r_wr_addr[7:0];
                    r_mem_din    <= {w_lhs, w_rhs};
                    r_wr_addr    <= r_wr_addr + 9'd1;
                    r_char_count <= w_len;
                    r_line_start <= w_start;
                    if (in_last) begin
                        r_ptr_we   <= 1'b1;
                        r_ptr_line <= r_line_count[7:0];
                        r_ptr_data <= {w_len, w_start};
                    end
                end
            end
            if (r_state == COMMIT) begin
                r_line_count <= r_line_count + 9'd1;
                if (w_state_next == FULL) r_full <= 1'b1;
            end
        end
    end

`ifdef LINE_WRITER_ASCII_CHECK_EN
    logic r_err_ascii;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_err_ascii <= 1'b0;
        else if (w_taking && !w_overflow && w_bad_byte) r_err_ascii <= 1'b1;
    end

    assign err_ascii = r_err_ascii;
`else
    logic w_unused;
    assign w_unused = w_bad_byte;
`endif

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign ptr_we       = r_ptr_we;
    assign ptr_line     = r_ptr_line;
    assign ptr_data     = r_ptr_data;
    assign line_count   = r_line_count[7:0];
    assign full         = r_full;
    assign err_overflow = r_err_overflow;

endmodule
